// File: rtl/rsa_exp_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rsa_exp_sequencer
// Description : Left-to-right binary modular exponentiation sequencer.
//               Computes x^e mod m by issuing Montgomery multiplications to
//               an external multiplier via a start/done handshake.
// Option      : RSA_EXP_SKIP_LEADING_ZEROS_EN - adds a SCAN state that skips
//               leading zero exponent bits without issuing multiplications.
// Revision    : 1.0 - initial release
// ============================================================================
module rsa_exp_sequencer #(
  parameter int WIDTH = 512
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_modulus,
  input  logic [WIDTH-1:0] i_r_mod_m,
  input  logic [WIDTH-1:0] i_r2_mod_m,
  input  logic [WIDTH-1:0] i_exponent,
  input  logic [WIDTH-1:0] i_x,
  output logic             o_mult_start,
  output logic [WIDTH-1:0] o_mult_a,
  output logic [WIDTH-1:0] o_mult_b,
  output logic [WIDTH-1:0] o_mult_m,
  input  logic             i_mult_done,
  input  logic [WIDTH-1:0] i_mult_result,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result
);

  localparam int               IDX_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] C_IDX_TOP = IDX_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] C_ONE     = WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TO_MONT   = 3'd1,
    S_SQUARE    = 3'd2,
    S_MULTIPLY  = 3'd3,
    S_FROM_MONT = 3'd4,
`ifdef RSA_EXP_SKIP_LEADING_ZEROS_EN
    S_SCAN      = 3'd6,
`endif
    S_DONE      = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  // x and R^2 mod m are only needed for the first multiplication, so they
  // live directly in the operand registers rather than in separate copies.
  logic [WIDTH-1:0]   r_m;
  logic [WIDTH-1:0]   r_rmodm;
  logic [WIDTH-1:0]   r_e;
  logic [WIDTH-1:0]   r_xm;
  logic [WIDTH-1:0]   r_acc;
  logic [IDX_W-1:0]   r_idx;
  logic [WIDTH-1:0]   r_result;
  logic               r_mult_start;
  logic [WIDTH-1:0]   r_mult_a;
  logic [WIDTH-1:0]   r_mult_b;

  logic               w_latch;
  logic               w_issue;
  logic [WIDTH-1:0]   w_a_nxt;
  logic [WIDTH-1:0]   w_b_nxt;
  logic [WIDTH-1:0]   w_xm_nxt;
  logic [WIDTH-1:0]   w_acc_nxt;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [WIDTH-1:0]   w_result_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state and next multiplication; mult_done is consumed the cycle it arrives
  always_comb begin
    w_state_nxt  = r_state;
    w_latch      = 1'b0;
    w_issue      = 1'b0;
    w_a_nxt      = r_mult_a;
    w_b_nxt      = r_mult_b;
    w_xm_nxt     = r_xm;
    w_acc_nxt    = r_acc;
    w_idx_nxt    = r_idx;
    w_result_nxt = r_result;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_latch     = 1'b1;
          w_state_nxt = S_TO_MONT;
          w_issue     = 1'b1;
          w_a_nxt     = i_x;
          w_b_nxt     = i_r2_mod_m;
        end
      end
      S_TO_MONT: begin
        if (i_mult_done) begin
          w_xm_nxt  = i_mult_result;
          w_acc_nxt = r_rmodm;
          w_idx_nxt = C_IDX_TOP;
`ifdef RSA_EXP_SKIP_LEADING_ZEROS_EN
          w_state_nxt = S_SCAN;
`else
          w_state_nxt = S_SQUARE;
          w_issue     = 1'b1;
          w_a_nxt     = r_rmodm;
          w_b_nxt     = r_rmodm;
`endif
        end
      end
`ifdef RSA_EXP_SKIP_LEADING_ZEROS_EN
      S_SCAN: begin
        if (r_e[r_idx]) begin
          w_state_nxt = S_SQUARE;
          w_issue     = 1'b1;
          w_a_nxt     = r_acc;
          w_b_nxt     = r_acc;
        end else if (r_idx == '0) begin
          w_state_nxt = S_FROM_MONT;
          w_issue     = 1'b1;
          w_a_nxt     = r_acc;
          w_b_nxt     = C_ONE;
        end else begin
          w_idx_nxt = r_idx - 1'b1;
        end
      end
`endif
      S_SQUARE: begin
        if (i_mult_done) begin
          w_acc_nxt = i_mult_result;
          w_issue   = 1'b1;
          w_a_nxt   = i_mult_result;
          if (r_e[r_idx]) begin
            w_state_nxt = S_MULTIPLY;
            w_b_nxt     = r_xm;
          end else if (r_idx == '0) begin
            w_state_nxt = S_FROM_MONT;
            w_b_nxt     = C_ONE;
          end else begin
            w_idx_nxt = r_idx - 1'b1;
            w_b_nxt   = i_mult_result;
          end
        end
      end
      S_MULTIPLY: begin
        if (i_mult_done) begin
          w_acc_nxt = i_mult_result;
          w_issue   = 1'b1;
          w_a_nxt   = i_mult_result;
          if (r_idx == '0) begin
            w_state_nxt = S_FROM_MONT;
            w_b_nxt     = C_ONE;
          end else begin
            w_state_nxt = S_SQUARE;
            w_idx_nxt   = r_idx - 1'b1;
            w_b_nxt     = i_mult_result;
          end
        end
      end
      S_FROM_MONT: begin
        if (i_mult_done) begin
          w_result_nxt = i_mult_result;
          w_state_nxt  = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers: operands, accumulator, bit index, result
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_m          <= '0;
      r_rmodm      <= '0;
      r_e          <= '0;
      r_xm         <= '0;
      r_acc        <= '0;
      r_idx        <= '0;
      r_result     <= '0;
      r_mult_start <= 1'b0;
      r_mult_a     <= '0;
      r_mult_b     <= '0;
    end else begin
      if (w_latch) begin
        r_m     <= i_modulus;
        r_rmodm <= i_r_mod_m;
        r_e     <= i_exponent;
      end
      r_xm         <= w_xm_nxt;
      r_acc        <= w_acc_nxt;
      r_idx        <= w_idx_nxt;
      r_result     <= w_result_nxt;
      r_mult_start <= w_issue;
      r_mult_a     <= w_a_nxt;
      r_mult_b     <= w_b_nxt;
    end
  end

  assign o_mult_start = r_mult_start;
  assign o_mult_a     = r_mult_a;
  assign o_mult_b     = r_mult_b;
  assign o_mult_m     = r_m;
  assign o_result     = r_result;
  assign o_done       = (r_state == S_DONE);
  assign o_busy       = (r_state != S_IDLE) && (r_state != S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_rsa_exp_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rsa_exp_sequencer
// Description : Directed bench for rsa_exp_sequencer with a behavioural
//               3-cycle Montgomery multiplier. Expected counts follow the
//               RSA_EXP_SKIP_LEADING_ZEROS_EN setting of the build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rsa_exp_sequencer;

  localparam int W = 512;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         i_start = 1'b0;
  logic [W-1:0] i_modulus = '0;
  logic [W-1:0] i_r_mod_m = '0;
  logic [W-1:0] i_r2_mod_m = '0;
  logic [W-1:0] i_exponent = '0;
  logic [W-1:0] i_x = '0;
  logic         o_mult_start;
  logic [W-1:0] o_mult_a;
  logic [W-1:0] o_mult_b;
  logic [W-1:0] o_mult_m;
  logic         i_mult_done = 1'b0;
  logic [W-1:0] i_mult_result = '0;
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_result;

  int checks = 0;
  int failures = 0;
  int n_pulses = 0;

  rsa_exp_sequencer #(.WIDTH(W)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .i_start      (i_start),
    .i_modulus    (i_modulus),
    .i_r_mod_m    (i_r_mod_m),
    .i_r2_mod_m   (i_r2_mod_m),
    .i_exponent   (i_exponent),
    .i_x          (i_x),
    .o_mult_start (o_mult_start),
    .o_mult_a     (o_mult_a),
    .o_mult_b     (o_mult_b),
    .o_mult_m     (o_mult_m),
    .i_mult_done  (i_mult_done),
    .i_mult_result(i_mult_result),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_result     (o_result)
  );

  always #5 clk = ~clk;

  // a*b*2^-W mod m, bit-serial Montgomery reduction
  function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [W-1:0] m);
    logic [W+1:0] t;
    t = '0;
    for (int i = 0; i < W; i++) begin
      if (a[i]) t = t + {2'b00, b};
      if (t[0]) t = t + {2'b00, m};
      t = t >> 1;
    end
    if (t >= {2'b00, m}) t = t - {2'b00, m};
    return t[W-1:0];
  endfunction

  // 2^n mod m by repeated doubling
  function automatic logic [W-1:0] pow2mod(input int n, input logic [W-1:0] m);
    logic [W:0] t;
    t = {{W{1'b0}}, 1'b1};
    for (int i = 0; i < n; i++) begin
      t = t << 1;
      if (t >= {1'b0, m}) t = t - {1'b0, m};
    end
    return t[W-1:0];
  endfunction

  // Behavioural multiplier: 3-cycle latency, checks operand stability and pulse width
  logic         mdl_pend = 1'b0;
  int           mdl_cnt = 0;
  logic [W-1:0] mdl_a, mdl_b, mdl_res;
  always @(negedge clk) begin
    i_mult_done = 1'b0;
    if (mdl_pend) begin
      if (o_busy) begin
        checks = checks + 1;
        if (o_mult_a !== mdl_a || o_mult_b !== mdl_b) begin
          failures = failures + 1;
          $display("FAIL operand_stable: a=%0h b=%0h required a=%0h b=%0h",
                   o_mult_a, o_mult_b, mdl_a, mdl_b);
        end
        if (o_mult_start) begin
          failures = failures + 1;
          $display("FAIL start_pulse_width: mult_start=1 during pending op, required 0");
        end
      end
      mdl_cnt = mdl_cnt - 1;
      if (mdl_cnt == 0) begin
        i_mult_done   = 1'b1;
        i_mult_result = mdl_res;
        mdl_pend      = 1'b0;
      end
    end else if (o_mult_start) begin
      n_pulses = n_pulses + 1;
      mdl_a    = o_mult_a;
      mdl_b    = o_mult_b;
      mdl_res  = mont(o_mult_a, o_mult_b, o_mult_m);
      mdl_cnt  = 3;
      mdl_pend = 1'b1;
    end
  end

  task automatic launch(input logic [W-1:0] m, input logic [W-1:0] x, input logic [W-1:0] e);
    @(negedge clk);
    i_modulus  = m;
    i_x        = x;
    i_exponent = e;
    i_r_mod_m  = pow2mod(W, m);
    i_r2_mod_m = pow2mod(2 * W, m);
    i_start    = 1'b1;
    n_pulses   = 0;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (o_done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks = checks + 1;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_mult_start !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL reset_ctrl: busy=%b done=%b mult_start=%b required 0 0 0",
               o_busy, o_done, o_mult_start);
    end
    checks = checks + 1;
    if (o_result !== '0 || o_mult_a !== '0 || o_mult_b !== '0 || o_mult_m !== '0) begin
      failures = failures + 1;
      $display("FAIL reset_data: result=%0h a=%0h b=%0h m=%0h required all 0",
               o_result, o_mult_a, o_mult_b, o_mult_m);
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    bit ok;
    launch(497, 4, 13);
    checks = checks + 1;
    if (o_busy !== 1'b1 || o_mult_start !== 1'b1 || o_mult_a !== W'(4)
        || o_mult_b !== pow2mod(2 * W, 497)) begin
      failures = failures + 1;
      $display("FAIL first_issue: busy=%b start=%b a=%0h b=%0h required 1 1 4 %0h",
               o_busy, o_mult_start, o_mult_a, o_mult_b, pow2mod(2 * W, 497));
    end
    i_x = 99; i_exponent = 7; i_modulus = 1001; i_r_mod_m = 3;
    @(negedge clk);
    checks = checks + 1;
    if (o_mult_m !== W'(497)) begin
      failures = failures + 1;
      $display("FAIL mult_m_latched: got %0d required 497", o_mult_m);
    end
    wait_done(ok);
    checks = checks + 1;
    if (!ok || o_result !== W'(445) || o_busy !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL basic_result: done=%b result=%0d busy=%b required 1 445 0",
               o_done, o_result, o_busy);
    end
  endtask

  task automatic test_exp_zero;
    bit ok;
    int exp_pulses;
`ifdef RSA_EXP_SKIP_LEADING_ZEROS_EN
    exp_pulses = 2;
`else
    exp_pulses = W + 2;
`endif
    launch(497, 4, 0);
    wait_done(ok);
    checks = checks + 1;
    if (!ok || o_result !== W'(1)) begin
      failures = failures + 1;
      $display("FAIL exp_zero_result: done=%b result=%0d required 1 1", o_done, o_result);
    end
    checks = checks + 1;
    if (n_pulses != exp_pulses) begin
      failures = failures + 1;
      $display("FAIL exp_zero_count: got %0d pulses required %0d", n_pulses, exp_pulses);
    end
  endtask

  task automatic test_exp_one;
    bit ok;
    launch(497, 200, 1);
    wait_done(ok);
    checks = checks + 1;
    if (!ok || o_result !== W'(200)) begin
      failures = failures + 1;
      $display("FAIL exp_one_result: done=%b result=%0d required 1 200", o_done, o_result);
    end
  endtask

  task automatic test_mult_count;
    bit ok;
    int exp_pulses;
`ifdef RSA_EXP_SKIP_LEADING_ZEROS_EN
    exp_pulses = 9;
`else
    exp_pulses = 517;
`endif
    launch(497, 4, 11);
    wait_done(ok);
    checks = checks + 1;
    if (!ok || o_result !== W'(121)) begin
      failures = failures + 1;
      $display("FAIL count_result: done=%b result=%0d required 1 121", o_done, o_result);
    end
    checks = checks + 1;
    if (n_pulses != exp_pulses) begin
      failures = failures + 1;
      $display("FAIL mult_count: got %0d pulses required %0d", n_pulses, exp_pulses);
    end
  endtask

  task automatic test_start_while_busy;
    bit ok;
    launch(497, 4, 13);
    repeat (20) @(negedge clk);
    i_x = 5; i_exponent = 3; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_done(ok);
    checks = checks + 1;
    if (!ok || o_result !== W'(445)) begin
      failures = failures + 1;
      $display("FAIL busy_start_ignored: done=%b result=%0d required 1 445", o_done, o_result);
    end
    launch(497, 5, 3);
    checks = checks + 1;
    if (o_done !== 1'b0 || o_busy !== 1'b1) begin
      failures = failures + 1;
      $display("FAIL restart_from_done: done=%b busy=%b required 0 1", o_done, o_busy);
    end
    wait_done(ok);
    checks = checks + 1;
    if (!ok || o_result !== W'(125)) begin
      failures = failures + 1;
      $display("FAIL restart_result: done=%b result=%0d required 1 125", o_done, o_result);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int p;
    launch(497, 4, 13);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (n_pulses >= 3) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks = checks + 1;
    if (!ok) begin
      failures = failures + 1;
      $display("FAIL reach_square: got %0d pulses required 3", n_pulses);
    end
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    checks = checks + 1;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_result !== '0) begin
      failures = failures + 1;
      $display("FAIL mid_reset: busy=%b done=%b result=%0d required 0 0 0",
               o_busy, o_done, o_result);
    end
    p = n_pulses;
    repeat (8) @(negedge clk);
    checks = checks + 1;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || n_pulses != p) begin
      failures = failures + 1;
      $display("FAIL stray_done: busy=%b done=%b pulses=%0d required 0 0 %0d",
               o_busy, o_done, n_pulses, p);
    end
    launch(497, 4, 13);
    wait_done(ok);
    checks = checks + 1;
    if (!ok || o_result !== W'(445)) begin
      failures = failures + 1;
      $display("FAIL after_reset_result: done=%b result=%0d required 1 445", o_done, o_result);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_exp_zero;
    test_exp_one;
    test_mult_count;
    test_start_while_busy;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rsa_exp_sequencer.md
# rsa_exp_sequencer

Left-to-right binary modular exponentiation sequencer. Computes x^e mod m by issuing Montgomery multiplications to an external Montgomery multiplier core through a start/done handshake. It sits directly below the top-level RSA command wrapper, which loads the operands, pulses `start` and waits on `done`. Inputs are taken already in binary (non-Montgomery) form, along with R mod m and R² mod m precomputed by software.

## Interface
- `WIDTH`, 512, operand width in bits; also the number of exponent bits scanned.
- `clk`  in  1  rising-edge clock
- `resetn`  in  1  reset, synchronous, active-low
- `start`  in  1  begin exponentiation; sampled only in IDLE and DONE
- `modulus`  in  WIDTH  m, odd, m < 2^WIDTH
- `r_mod_m`  in  WIDTH  R mod m, where R = 2^WIDTH
- `r2_mod_m`  in  WIDTH  R² mod m
- `exponent`  in  WIDTH  e
- `x`  in  WIDTH  base, x < m
- `mult_start`  out  1  one-cycle pulse launching a Montgomery multiplication
- `mult_a`  out  WIDTH  multiplier operand a; stable from the pulse until `mult_done`
- `mult_b`  out  WIDTH  multiplier operand b; same stability rule as `mult_a`
- `mult_m`  out  WIDTH  modulus to the multiplier; equals the latched m
- `mult_done`  in  1  one-cycle pulse from the multiplier; `mult_result` is valid in the same cycle
- `mult_result`  in  WIDTH  a·b·R⁻¹ mod m
- `busy`  out  1  high in every state except IDLE and DONE
- `done`  out  1  level; high in DONE
- `result`  out  WIDTH  x^e mod m; valid while `done` = 1

## Operation
- **Start.** A `start` pulse in IDLE or DONE latches all five operands into internal registers and clears `done`. Later input changes have no effect until the next start. `start` in any other state is ignored.
- **Registers.**
  - xm: x in Montgomery form.
  - A: running accumulator.
  - idx: bit index, $clog2(WIDTH) bits wide.
- **States:** IDLE, TO_MONT, SCAN (only when the configuration macro is defined), SQUARE, MULTIPLY, FROM_MONT, DONE.
- **TO_MONT.** Issue MM(x, r2_mod_m). On `mult_done`:
  - xm ← `mult_result`.
  - A ← r_mod_m.
  - idx ← WIDTH-1.
  - Go to SCAN if the macro is defined, otherwise SQUARE.
- **SQUARE.** Issue MM(A, A). On `mult_done`:
  - A ← `mult_result`.
  - If e[idx] = 1, go to MULTIPLY.
  - Otherwise, if idx = 0, go to FROM_MONT.
  - Otherwise decrement idx and stay in SQUARE.
- **MULTIPLY.** Issue MM(A, xm). On `mult_done`:
  - A ← `mult_result`.
  - If idx = 0, go to FROM_MONT.
  - Otherwise decrement idx and return to SQUARE.
- **idx at 0.** idx never wraps. Reaching 0 always exits the loop.
- **FROM_MONT.** Issue MM(A, 1). On `mult_done`: `result` ← `mult_result`, go to DONE.
- **DONE.** `done` = 1 and `result` is held. On `start`, behave as a start from IDLE.
- **Exponent zero.** Result = MM(R mod m, 1) = 1.
- **Modulus.** `mult_m` = latched m in all states.
- **Stray `mult_done`.** A `mult_done` in IDLE, DONE or SCAN is ignored.

## Timing
- **Reset values.** While `resetn` = 0 at a clock edge:
  - state ← IDLE.
  - `mult_start`, `busy`, `done` ← 0.
  - `result`, `mult_a`, `mult_b`, A, xm ← 0.
  - idx ← 0.
- **Reset mid-operation.** Same as above. The operation is abandoned with no `done` pulse. Resetting the multiplier is the responsibility of the parent.
- **Handshake.**
  - `start` sampled at edge N → state TO_MONT and `mult_start` = 1 during cycle N+1, with operands already valid.
  - `mult_start` is high for exactly one cycle per multiplication.
  - The next multiplication's `mult_start` is asserted in the cycle after the `mult_done` that completed the previous one.
  - `mult_done` and `mult_result` are consumed combinationally in the same cycle they are seen.
- **`done` latency.** `done` rises the cycle after the FROM_MONT `mult_done`.
- **`busy`.** Rises the cycle after `start` and falls in the same cycle `done` rises.
- **Multiplication count.** Total = 2 + WIDTH + popcount(e) without the macro. No other cycle overhead beyond one cycle per multiplication.

## Configuration
- **`RSA_EXP_SKIP_LEADING_ZEROS_EN` defined:** SCAN state is compiled in.
  - SCAN examines e[idx] at one bit per cycle, with no multiplications.
  - If e[idx] = 1, go to SQUARE.
  - Else if idx = 0 (e = 0), go to FROM_MONT.
  - Else decrement idx.
  - Multiplication count becomes 2 + (msb_index(e)+1) + popcount(e), or 2 when e = 0.
  - Results are identical to the macro-undefined build.
- **`RSA_EXP_SKIP_LEADING_ZEROS_EN` undefined:** all WIDTH bits are processed starting from the top.

## Test plan
- **Basic result.** m=497, x=4, e=13, r_mod_m/r2_mod_m from the bench model, behavioural multiplier with 3-cycle latency → `done`=1, `result`=445.
- **Exponent zero.** e=0, m=497, x=4 → `result`=1.
  - Exactly 2 `mult_start` pulses with the macro defined; WIDTH+2 pulses without it.
- **Exponent one.** e=1, m=497, x=200 → `result`=200.
- **Multiplication count.** e=11, WIDTH=512 → 517 `mult_start` pulses without the macro, 9 with it.
  - Each `mult_a`/`mult_b` is checked stable from its pulse until `mult_done`.
- **Start while busy.** Second `start` with x=5 issued mid-run of the x=4, e=13 case → ignored, `result`=445.
  - A new `start` issued from DONE with x=5, e=3 → `done` drops the next cycle, then `result`=125.
- **Reset mid-operation.** `resetn`=0 for 1 cycle during SQUARE → next cycle `busy`=0, `done`=0, `result`=0.
  - A trailing `mult_done` afterwards is ignored.
  - A fresh run then yields 445.
